// File: rtl/dpu_result_packer.sv
// Packs per-cycle DPU result words into bulk-width lines and queues them in a small output FIFO.
// Optional DPU_PACKER_DROP_CNT_EN adds a saturating dropped-word counter on port drop_count.
module dpu_result_packer #(
  parameter int unsigned WORD_BITWIDTH = 16,
  parameter int unsigned BULK_BITWIDTH = 256,
  parameter int unsigned FIFO_DEPTH    = 2,
  parameter int unsigned COUNT_WIDTH   = 16,
  localparam int unsigned WORDS        = BULK_BITWIDTH / WORD_BITWIDTH,
  localparam int unsigned CW           = $clog2(WORDS) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_valid,
  input  logic [CW-1:0]            cfg_words,
  input  logic [COUNT_WIDTH-1:0]   cfg_lines,
  input  logic                     word_valid,
  input  logic [WORD_BITWIDTH-1:0] word_data,
  output logic                     bulk_valid,
  input  logic                     bulk_ready,
  output logic [BULK_BITWIDTH-1:0] bulk_data,
  output logic                     bulk_last,
  output logic                     busy,
`ifdef DPU_PACKER_DROP_CNT_EN
  output logic                     overflow,
  output logic [COUNT_WIDTH-1:0]   drop_count
`else
  output logic                     overflow
`endif
);

  localparam int unsigned PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNTW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StPack, StDrain} state_e;

  state_e                   state_q, state_d;
  logic [CW-1:0]            wpl_q, idx_q;
  logic [COUNT_WIDTH-1:0]   lines_left_q;
  logic [BULK_BITWIDTH-1:0] asm_q, line;
  logic                     overflow_q;
  logic [BULK_BITWIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic                     fifo_last_q [FIFO_DEPTH];
  logic [PW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]          count_q, count_d;
  logic [CW-1:0]            cfg_wpl;

  logic cfg_accept, pop, full, push_ok, word_in, completing, push, drop, last_line;

  assign cfg_accept = (state_q == StIdle) && cfg_valid && (cfg_lines != '0);
  assign pop        = (count_q != '0) && bulk_ready;
  assign full       = (count_q == CNTW'(FIFO_DEPTH));
  // A full FIFO still accepts a line when its head leaves on the same edge.
  assign push_ok    = !full || pop;
  assign word_in    = (state_q == StPack) && word_valid;
  assign completing = word_in && (idx_q == wpl_q - CW'(1));
  assign push       = completing && push_ok;
  assign drop       = completing && !push_ok;
  assign last_line  = (lines_left_q == COUNT_WIDTH'(1));
  assign count_d    = count_q + CNTW'(push) - CNTW'(pop);
  assign cfg_wpl    = ((cfg_words == '0) || (cfg_words > CW'(WORDS))) ? CW'(WORDS) : cfg_words;

  always_comb begin
    line = asm_q;
    line[32'(idx_q) * WORD_BITWIDTH +: WORD_BITWIDTH] = word_data;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cfg_accept) state_d = StPack;
      StPack:  if (push && last_line) state_d = StDrain;
      StDrain: if (count_d == '0) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy       = (state_q != StIdle);
    bulk_valid = (count_q != '0);
    bulk_data  = bulk_valid ? fifo_data_q[rd_ptr_q] : '0;
    bulk_last  = bulk_valid && fifo_last_q[rd_ptr_q];
    overflow   = overflow_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wpl_q        <= CW'(WORDS);
      idx_q        <= '0;
      lines_left_q <= '0;
      asm_q        <= '0;
      overflow_q   <= 1'b0;
    end else if (cfg_accept) begin
      wpl_q        <= cfg_wpl;
      idx_q        <= '0;
      lines_left_q <= cfg_lines;
      asm_q        <= '0;
      overflow_q   <= 1'b0;
    end else if (push) begin
      idx_q        <= '0;
      asm_q        <= '0;
      lines_left_q <= lines_left_q - COUNT_WIDTH'(1);
    end else if (drop) begin
      overflow_q   <= 1'b1;
    end else if (word_in) begin
      asm_q        <= line;
      idx_q        <= idx_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= line;
      fifo_last_q[wr_ptr_q] <= last_line;
    end
  end

`ifdef DPU_PACKER_DROP_CNT_EN
  logic [COUNT_WIDTH-1:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || cfg_accept)             drop_cnt_q <= '0;
    else if (drop && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + COUNT_WIDTH'(1);
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule
